// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the pin signals, deserialises
// 11-bit frames, tracks E0/F0 prefixes and keeps the held up/down/left/right mask.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW_RAW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW      = (TW_RAW > 18) ? TW_RAW : 18;

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX   = '1;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Synchronisers and clock filter
  logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic            filt_q, filt_d;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic            fall_q, fall_d;

  // Receiver
  state_t          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            byte_ok_q, byte_ok_d;
  logic            frame_err_q, frame_err_d;

  // Decoder
  logic [7:0]      scan_code_q, scan_code_d;
  logic            scan_valid_q, scan_valid_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [3:0]      arrow_q, arrow_d;
  logic [3:0]      letter_q, letter_d;

  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;
  end

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d     = clk_s2_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    byte_ok_d   = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

    if ((state_q == ST_IDLE) || fall_q) begin
      tmo_d = '0;
    end

    if (fall_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (dat_s2_q && (^{shift_q, parity_q})) begin
            byte_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (tmo_q == TMO_LAST)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      byte_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      byte_ok_q   <= byte_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  // shift_q is stable while the receiver sits in IDLE, so it doubles as the received byte.
  always_comb begin
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    ext_d        = ext_q;
    brk_d        = brk_q;
    arrow_d      = arrow_q;
    letter_d     = letter_q;

    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_ok_q) begin
      scan_code_d  = shift_q;
      scan_valid_d = 1'b1;
      if (shift_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == CODE_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q) begin
          case (shift_q)
            8'h75:   arrow_d[0] = ~brk_q;
            8'h72:   arrow_d[1] = ~brk_q;
            8'h6B:   arrow_d[2] = ~brk_q;
            8'h74:   arrow_d[3] = ~brk_q;
            default: arrow_d    = arrow_q;
          endcase
        end else begin
          case (shift_q)
            8'h1D:   letter_d[0] = ~brk_q;
            8'h1B:   letter_d[1] = ~brk_q;
            8'h1C:   letter_d[2] = ~brk_q;
            8'h23:   letter_d[3] = ~brk_q;
            default: letter_d    = letter_q;
          endcase
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      arrow_q      <= '0;
      letter_q     <= '0;
    end else begin
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      arrow_q      <= arrow_d;
      letter_q     <= letter_d;
    end
  end

  assign key        = arrow_q | letter_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: frames are bit-banged on the PS/2 pins,
// expected scan/error events are queued and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 30;
  localparam int LAT  = 2 + FILT + 2;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic [3:0] key;
  } ev_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_fall = 0;
  bit  tmo_mode = 1'b0;
  ev_t sb[$];
  ev_t ev;
  int  dly;

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key        (key),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(HALF / 3);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF - HALF / 3 - 3);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit glitch,
                      input logic [3:0] exp_key);
    logic par;
    ev_t  e;
    e.is_err = bad_par;
    e.code   = b;
    e.key    = exp_key;
    sb.push_back(e);
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(1'b1, glitch);
    ps2_data = 1'b1;
  endtask

  task automatic partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      wait_cyc(1);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 0);
  endtask

  always @(negedge pclk) begin
    if (rst_n && (scan_valid || frame_err)) begin
      dly = cyc - last_fall;
      if (sb.size() == 0) begin
        chk("event_expected", 32'(sb.size()), 1);
      end else begin
        ev = sb.pop_front();
        chk("event_kind_err", 32'(frame_err), 32'(ev.is_err));
        chk("event_kind_scan", 32'(scan_valid), 32'(!ev.is_err));
        chk("key", 32'(key), 32'(ev.key));
        if (!ev.is_err) begin
          chk("scan_code", 32'(scan_code), 32'(ev.code));
          chk("scan_latency", 32'(dly), LAT);
        end else if (tmo_mode) begin
          chk("timeout_latency_in_window", 32'(dly >= TMO && dly <= TMO + 16), 1);
        end else begin
          chk("err_latency", 32'(dly), LAT - 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(5);
    chk("reset_key", 32'(key), 0);
    chk("reset_scan_code", 32'(scan_code), 0);
    chk("reset_scan_valid", 32'(scan_valid), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    wait_cyc(20);

    send(8'hE0, 0, 0, 4'b0000);
    send(8'h75, 0, 0, 4'b0001);
    drain();

    send(8'hE0, 0, 0, 4'b0001);
    send(8'hF0, 0, 0, 4'b0001);
    send(8'h75, 0, 0, 4'b0000);
    drain();

    send(8'h1C, 0, 0, 4'b0100);
    send(8'hE0, 0, 0, 4'b0100);
    send(8'h6B, 0, 0, 4'b0100);
    send(8'hE0, 0, 0, 4'b0100);
    send(8'hF0, 0, 0, 4'b0100);
    send(8'h6B, 0, 0, 4'b0100);
    send(8'hF0, 0, 0, 4'b0100);
    send(8'h1C, 0, 0, 4'b0000);
    drain();

    send(8'h1D, 1, 0, 4'b0000);
    send(8'hE0, 0, 0, 4'b0000);
    send(8'h74, 0, 0, 4'b1000);
    drain();

    begin
      ev_t e;
      e.is_err = 1'b1;
      e.code   = 8'h00;
      e.key    = 4'b1000;
      tmo_mode = 1'b1;
      sb.push_back(e);
      partial(8'h55, 3);
      wait_cyc(TMO + 60);
      chk("timeout_seen", 32'(sb.size()), 0);
      tmo_mode = 1'b0;
    end
    send(8'h23, 0, 0, 4'b1000);
    drain();

    send(8'hAA, 0, 0, 4'b1000);
    send(8'hE0, 0, 0, 4'b1000);
    send(8'hF0, 0, 0, 4'b1000);
    send(8'h74, 0, 0, 4'b1000);
    send(8'h75, 0, 0, 4'b1000);
    send(8'hF0, 0, 0, 4'b1000);
    send(8'h23, 0, 0, 4'b0000);
    drain();

    send(8'h1B, 0, 0, 4'b0010);
    send(8'h1D, 0, 0, 4'b0011);
    send(8'h1D, 0, 0, 4'b0011);
    send(8'hE0, 0, 1, 4'b0011);
    send(8'h6B, 0, 1, 4'b0111);
    drain();

    send(8'hE0, 0, 0, 4'b0111);
    send(8'h42, 1, 0, 4'b0111);
    send(8'h74, 0, 0, 4'b0111);
    drain();

    partial(8'h1C, 4);
    rst_n = 1'b0;
    #1;
    chk("midreset_key", 32'(key), 0);
    chk("midreset_scan_code", 32'(scan_code), 0);
    chk("midreset_scan_valid", 32'(scan_valid), 0);
    chk("midreset_frame_err", 32'(frame_err), 0);
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(20);
    send(8'h1C, 0, 0, 4'b0100);
    drain();
    wait_cyc(50);
    chk("final_key", 32'(key), 32'(4'b0100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
